keypad_button_scanner: RTL and testbench

Front-end input stage for the vending-machine controller. It scans the 4x4 matrix keypad column by column, synchronizes and debounces the keypad and the five push-buttons, and produces level (`*_press`) and one-cycle rising-edge (`*_edge`) vectors. The restock manager consumes `key_press`/`key_edge`. The payment block consumes `bt_press`/`bt_edge`.

---
 rtl/keypad_button_scanner.sv | 174 +++++++++++++++++
 tb/tb_keypad_button_scanner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_button_scanner.sv
// keypad_button_scanner
// Front-end input stage: scans a 4x4 active-low matrix keypad one column at a
// time, synchronizes and debounces the keypad and five push-buttons, and
// produces debounced levels plus one-cycle rising-edge pulses.
//
// Ports:
//   clk        system clock (single domain)
//   rst        synchronous active-high reset
//   row[3:0]   keypad rows, active-low, asynchronous
//   bt[4:0]    push-buttons, active-high, asynchronous
//   col[3:0]   keypad column drive, active-low, one bit low at a time
//   key_press  debounced key levels, key k = 4*column + row
//   key_edge   one-cycle pulse on each key_press 0->1 transition
//   bt_press   debounced button levels
//   bt_edge    one-cycle pulse on each bt_press 0->1 transition
//
// Column FSM:
//   state | meaning
//   COL0  | col = 1110, rows sampled into frame[3:0] on last dwell cycle
//   COL1  | col = 1101, rows sampled into frame[7:4]
//   COL2  | col = 1011, rows sampled into frame[11:8]
//   COL3  | col = 0111, rows complete the frame and drive the debouncer
module keypad_button_scanner #(
    parameter int SCAN_DIV  = 100000,
    parameter int DEB_SCANS = 4,
    parameter int BT_DEB    = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    input  logic [4:0]  bt,
    output logic [3:0]  col,
    output logic [15:0] key_press,
    output logic [15:0] key_edge,
    output logic [4:0]  bt_press,
    output logic [4:0]  bt_edge
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEB_SCANS + 1);
    localparam int BW = $clog2(BT_DEB + 1);
    localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(DEB_SCANS - 1);
    localparam logic [BW-1:0] BT_LAST     = BW'(BT_DEB - 1);

    typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_state_t;

    col_state_t    state, state_nxt;
    logic [DW-1:0] dwell;
    logic          dwell_last;

    logic [3:0]    row_s1, row_s2;
    logic [4:0]    bt_s1, bt_s2;

    logic [11:0]   frame;
    logic [15:0]   prev_frame;
    logic [15:0]   frame_full;
    logic          frame_done;
    logic [SW-1:0] stable;
    logic [SW-1:0] stable_nxt;

    logic [BW-1:0] bt_cnt;

    // Two-flop synchronizers; rows idle high, buttons idle low.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1 <= 4'b1111;
            row_s2 <= 4'b1111;
            bt_s1  <= 5'b0;
            bt_s2  <= 5'b0;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            bt_s1  <= bt;
            bt_s2  <= bt_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= COL0;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        col        = 4'b1110;
        dwell_last = (dwell == DWELL_LAST);
        case (state)
            COL0: begin
                col = 4'b1110;
                if (dwell_last) state_nxt = COL1;
            end
            COL1: begin
                col = 4'b1101;
                if (dwell_last) state_nxt = COL2;
            end
            COL2: begin
                col = 4'b1011;
                if (dwell_last) state_nxt = COL3;
            end
            COL3: begin
                col = 4'b0111;
                if (dwell_last) state_nxt = COL0;
            end
            default: begin
                col       = 4'b1110;
                state_nxt = COL0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)             dwell <= '0;
        else if (dwell_last) dwell <= '0;
        else                 dwell <= dwell + DW'(1);
    end

    // Column 3 is never stored: its sample completes the frame directly.
    always_comb begin
        frame_full = {~row_s2, frame};
        frame_done = dwell_last && (state == COL3);
        stable_nxt = '0;
        if (frame_full == prev_frame) begin
            if (stable == STABLE_LAST) stable_nxt = stable;
            else                       stable_nxt = stable + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame      <= '0;
            prev_frame <= '0;
            stable     <= '0;
            key_press  <= '0;
            key_edge   <= '0;
        end else begin
            key_edge <= '0;
            if (dwell_last && (state != COL3))
                frame[{state, 2'b00} +: 4] <= ~row_s2;
            if (frame_done) begin
                prev_frame <= frame_full;
                stable     <= stable_nxt;
                if (stable_nxt == STABLE_LAST) begin
                    key_press <= frame_full;
                    key_edge  <= frame_full & ~key_press;
                end
            end
        end
    end

    // One shared counter: any mismatch against bt_press keeps it counting,
    // only a momentary match restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            bt_cnt   <= '0;
            bt_press <= '0;
            bt_edge  <= '0;
        end else begin
            bt_edge <= '0;
            if (bt_s2 != bt_press) begin
                if (bt_cnt == BT_LAST) begin
                    bt_press <= bt_s2;
                    bt_edge  <= bt_s2 & ~bt_press;
                    bt_cnt   <= '0;
                end else begin
                    bt_cnt <= bt_cnt + BW'(1);
                end
            end else begin
                bt_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_button_scanner.sv
module tb_keypad_button_scanner;

    localparam int SCAN_DIV  = 4;
    localparam int DEB_SCANS = 2;
    localparam int BT_DEB    = 8;
    localparam int FRAME     = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [4:0]  bt = 5'b0;
    logic [3:0]  col;
    logic [15:0] key_press, key_edge;
    logic [4:0]  bt_press, bt_edge;

    logic [15:0] held = 16'h0;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int          n = 0;
    logic [15:0] hist[$];
    logic [15:0] exp_kp, exp_ke;
    logic [4:0]  bt_q[$];
    logic [4:0]  exp_bp, exp_be;
    int          bcnt;

    keypad_button_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEB_SCANS(DEB_SCANS),
        .BT_DEB   (BT_DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .bt       (bt),
        .col      (col),
        .key_press(key_press),
        .key_edge (key_edge),
        .bt_press (bt_press),
        .bt_edge  (bt_edge)
    );

    always #5 clk = ~clk;

    // Physical keypad: a held key shorts its row to its column.
    always_comb begin
        row = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (held[4*c+r] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, n, obs, expv);
        end
    endtask

    task automatic model_reset();
        n = 0;
        hist.delete();
        hist.push_back(16'h0);
        bt_q.delete();
        exp_kp = '0; exp_ke = '0;
        exp_bp = '0; exp_be = '0;
        bcnt = 0;
    endtask

    task automatic tick();
        logic [4:0] used;
        logic       same;
        logic [3:0] exp_col;
        @(posedge clk); #1;
        n++;
        // buttons: logic sees the input two edges late
        bt_q.push_back(bt);
        used = (bt_q.size() >= 3) ? bt_q[bt_q.size()-3] : 5'b0;
        exp_be = '0;
        if (used != exp_bp) begin
            bcnt++;
            if (bcnt == BT_DEB) begin
                exp_be = used & ~exp_bp;
                exp_bp = used;
                bcnt   = 0;
            end
        end else begin
            bcnt = 0;
        end
        // keys: a frame completes every FRAME cycles
        exp_ke = '0;
        if (n % FRAME == 0) begin
            hist.push_back(held);
            same = 1'b1;
            if (hist.size() < DEB_SCANS) same = 1'b0;
            else
                for (int i = 0; i < DEB_SCANS; i++)
                    if (hist[hist.size()-1-i] != held) same = 1'b0;
            if (same) begin
                exp_ke = held & ~exp_kp;
                exp_kp = held;
            end
        end
        exp_col = ~(4'b0001 << 2'((n / SCAN_DIV) % 4));
        chk("col", {12'h0, col}, {12'h0, exp_col});
        chk("key_press", key_press, exp_kp);
        chk("key_edge", key_edge, exp_ke);
        chk("bt_press", {11'h0, bt_press}, {11'h0, exp_bp});
        chk("bt_edge", {11'h0, bt_edge}, {11'h0, exp_be});
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(posedge clk); #1;
            chk("rst_col", {12'h0, col}, 16'h000e);
            chk("rst_key_press", key_press, 16'h0);
            chk("rst_key_edge", key_edge, 16'h0);
            chk("rst_bt_press", {11'h0, bt_press}, 16'h0);
            chk("rst_bt_edge", {11'h0, bt_edge}, 16'h0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_frame(input logic [15:0] keys);
        held = keys;
        repeat (FRAME) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] k;
        model_reset();

        // 1: reset and column walk, idle keypad
        do_reset(3);
        run_frame(16'h0);
        run_frame(16'h0);

        // 2: single key 9
        run_frame(16'h0200);
        chk("k9_not_yet", key_press, 16'h0);
        run_frame(16'h0200);
        chk("k9_press", key_press, 16'h0200);
        chk("k9_edge", key_edge, 16'h0200);
        run_frame(16'h0200);
        chk("k9_edge_gone", key_edge, 16'h0);
        run_frame(16'h0);
        chk("k9_hold_after_release", key_press, 16'h0200);
        run_frame(16'h0);
        chk("k9_release", key_press, 16'h0);
        chk("k9_release_noedge", key_edge, 16'h0);

        // 3: bounce, key 0 in alternate frames
        for (int i = 0; i < 6; i++) run_frame((i % 2 == 0) ? 16'h0001 : 16'h0000);
        chk("bounce_press", key_press, 16'h0);

        // 4: two keys then reset during COL2
        run_frame(16'h8001);
        run_frame(16'h8001);
        chk("k0k15_press", key_press, 16'h8001);
        chk("k0k15_edge", key_edge, 16'h8001);
        while (((n / SCAN_DIV) % 4) != 2) tick();
        tick();
        do_reset(1);
        held = 16'h0;

        // 5: button debounce
        bt = 5'b00100;
        repeat (5) tick();
        bt = 5'b0;
        repeat (12) tick();
        chk("bt_short_pulse", {11'h0, bt_press}, 16'h0);
        bt = 5'b00100;
        repeat (9) tick();
        chk("bt_not_yet", {11'h0, bt_press}, 16'h0);
        tick();
        chk("bt_press_set", {11'h0, bt_press}, 16'h0004);
        chk("bt_edge_set", {11'h0, bt_edge}, 16'h0004);
        tick();
        chk("bt_edge_gone", {11'h0, bt_edge}, 16'h0);
        bt = 5'b0;
        repeat (9) tick();
        chk("bt_release_not_yet", {11'h0, bt_press}, 16'h0004);
        tick();
        chk("bt_release", {11'h0, bt_press}, 16'h0);
        chk("bt_release_noedge", {11'h0, bt_edge}, 16'h0);

        // random keys per frame and random button activity
        while (n % FRAME != 0) tick();
        for (int f = 0; f < 24; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                k = 16'h0;
                if ($urandom_range(0, 4) != 0)
                    repeat ($urandom_range(1, 3)) k[$urandom_range(0, 15)] = 1'b1;
                held = k;
            end
            repeat (FRAME) begin
                if ($urandom_range(0, 9) == 0) bt = 5'($urandom_range(0, 31));
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
